// File: rtl/bus_transfer_controller.sv
// bus_transfer_controller: queues register-to-register bus transfer requests
// and sequences each one as IDLE -> SETUP (source drives) -> TRANSFER (source
// drives, destination loads), then pulses DONE on the following IDLE cycle.
module bus_transfer_controller #(
    parameter int unsigned NUM_REGS    = 4,
    parameter int unsigned SEL_WIDTH   = 2,
    parameter int unsigned QUEUE_DEPTH = 4
) (
    input  logic                 i_CLOCK,
    input  logic                 i_RESET,
    input  logic                 i_REQ_VALID,
    output logic                 o_REQ_READY,
    input  logic [SEL_WIDTH-1:0] i_REQ_SRC,
    input  logic [SEL_WIDTH-1:0] i_REQ_DST,
    output logic [NUM_REGS-1:0]  o_WRITE_BUS,
    output logic [NUM_REGS-1:0]  o_READ_BUS,
    output logic                 o_DONE,
    output logic                 o_REJECT,
    output logic                 o_BUSY
);

    localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]   FULL_COUNT = CNT_W'(QUEUE_DEPTH);
    localparam logic [SEL_WIDTH:0] REG_LIMIT  = (SEL_WIDTH + 1)'(NUM_REGS);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SETUP    = 2'd1,
        ST_TRANSFER = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Request queue storage and bookkeeping
    logic [SEL_WIDTH-1:0] src_mem [QUEUE_DEPTH];
    logic [SEL_WIDTH-1:0] dst_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;

    logic                 queue_full;
    logic                 queue_empty;
    logic                 req_fire;
    logic                 req_bad;
    logic                 push;
    logic                 pop;

    logic [SEL_WIDTH-1:0] head_src;
    logic [SEL_WIDTH-1:0] head_dst;
    logic [SEL_WIDTH-1:0] cur_src;
    logic [SEL_WIDTH-1:0] cur_dst;

    logic [NUM_REGS-1:0]  write_next;
    logic [NUM_REGS-1:0]  read_next;
    logic                 done_next;

    function automatic logic [NUM_REGS-1:0] onehot(input logic [SEL_WIDTH-1:0] idx);
        return NUM_REGS'(1) << idx;
    endfunction

    assign queue_full  = (count == FULL_COUNT);
    assign queue_empty = (count == '0);
    assign head_src    = src_mem[rd_ptr];
    assign head_dst    = dst_mem[rd_ptr];

    // Ready depends only on occupancy so a same-cycle pop never feeds back into it
    assign o_REQ_READY = !queue_full;
    assign o_BUSY      = (state != ST_IDLE) || !queue_empty;

    // Requests naming the same register twice or an unimplemented register are dropped
    assign req_fire = i_REQ_VALID && o_REQ_READY && !i_RESET;
    assign req_bad  = (i_REQ_SRC == i_REQ_DST)
                   || ({1'b0, i_REQ_SRC} >= REG_LIMIT)
                   || ({1'b0, i_REQ_DST} >= REG_LIMIT);
    assign push     = req_fire && !req_bad;

    // Queue payload write; contents need no reset since pointers gate visibility
    always_ff @(posedge i_CLOCK) begin
        if (push) begin
            src_mem[wr_ptr] <= i_REQ_SRC;
            dst_mem[wr_ptr] <= i_REQ_DST;
        end
    end

    // Queue pointers and occupancy; push and pop in one cycle both take effect
    always_ff @(posedge i_CLOCK) begin
        if (i_RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // State register, current transfer latch and registered outputs
    always_ff @(posedge i_CLOCK) begin
        if (i_RESET) begin
            state       <= ST_IDLE;
            cur_src     <= '0;
            cur_dst     <= '0;
            o_WRITE_BUS <= '0;
            o_READ_BUS  <= '0;
            o_DONE      <= 1'b0;
            o_REJECT    <= 1'b0;
        end else begin
            state       <= state_next;
            o_WRITE_BUS <= write_next;
            o_READ_BUS  <= read_next;
            o_DONE      <= done_next;
            o_REJECT    <= req_fire && req_bad;
            if (pop) begin
                cur_src <= head_src;
                cur_dst <= head_dst;
            end
        end
    end

    // Next state and next values of the registered enables, keyed on the state being entered
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        write_next = '0;
        read_next  = '0;
        done_next  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!queue_empty) begin
                    pop        = 1'b1;
                    state_next = ST_SETUP;
                    write_next = onehot(head_src);
                end
            end
            ST_SETUP: begin
                state_next = ST_TRANSFER;
                write_next = onehot(cur_src);
                read_next  = onehot(cur_dst);
            end
            ST_TRANSFER: begin
                state_next = ST_IDLE;
                done_next  = 1'b1;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // head_dst is only consumed on pop; keep it visible for readability of the latch above
    logic unused_ok;
    assign unused_ok = &{1'b0, head_dst};

endmodule

// File: tb/tb_bus_transfer_controller.sv
// Directed and random checks for bus_transfer_controller (NUM_REGS=4, SEL_WIDTH=3, QUEUE_DEPTH=4).
module tb_bus_transfer_controller;

    localparam int unsigned NUM_REGS    = 4;
    localparam int unsigned SEL_WIDTH   = 3;
    localparam int unsigned QUEUE_DEPTH = 4;

    logic                 clk   = 1'b0;
    logic                 rst   = 1'b1;
    logic                 valid = 1'b0;
    logic [SEL_WIDTH-1:0] src   = '0;
    logic [SEL_WIDTH-1:0] dst   = '0;
    logic                 ready;
    logic [NUM_REGS-1:0]  wbus;
    logic [NUM_REGS-1:0]  rbus;
    logic                 done;
    logic                 reject;
    logic                 busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bus_transfer_controller #(
        .NUM_REGS   (NUM_REGS),
        .SEL_WIDTH  (SEL_WIDTH),
        .QUEUE_DEPTH(QUEUE_DEPTH)
    ) dut (
        .i_CLOCK    (clk),
        .i_RESET    (rst),
        .i_REQ_VALID(valid),
        .o_REQ_READY(ready),
        .i_REQ_SRC  (src),
        .i_REQ_DST  (dst),
        .o_WRITE_BUS(wbus),
        .o_READ_BUS (rbus),
        .o_DONE     (done),
        .o_REJECT   (reject),
        .o_BUSY     (busy)
    );

    function automatic logic [3:0] oh(input int i);
        return 4'b0001 << i;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; valid = 1'b1; src = 3'd1; dst = 3'd2;
        tick; tick;
        rst = 1'b0; valid = 1'b0;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (wbus !== 4'b0000) begin errors++; $display("FAIL reset_wbus: got %b want 0000", wbus); end
        checks++; if (rbus !== 4'b0000) begin errors++; $display("FAIL reset_rbus: got %b want 0000", rbus); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (reject !== 1'b0) begin errors++; $display("FAIL reset_reject: got %b want 0", reject); end
        tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_no_enqueue: busy got %b want 0", busy); end
    endtask

    task automatic test_single;
        valid = 1'b1; src = 3'd1; dst = 3'd3;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", ready); end
        tick;
        valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_queued: got %b want 1", busy); end
        checks++; if (wbus !== 4'b0000) begin errors++; $display("FAIL single_idle_wbus: got %b want 0000", wbus); end
        tick;
        checks++; if (wbus !== 4'b0010) begin errors++; $display("FAIL single_setup_wbus: got %b want 0010", wbus); end
        checks++; if (rbus !== 4'b0000) begin errors++; $display("FAIL single_setup_rbus: got %b want 0000", rbus); end
        tick;
        checks++; if (wbus !== 4'b0010) begin errors++; $display("FAIL single_xfer_wbus: got %b want 0010", wbus); end
        checks++; if (rbus !== 4'b1000) begin errors++; $display("FAIL single_xfer_rbus: got %b want 1000", rbus); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_xfer_done: got %b want 0", done); end
        tick;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL single_done: got %b want 1", done); end
        checks++; if ((wbus | rbus) !== 4'b0000) begin errors++; $display("FAIL single_done_enables: got %b/%b want 0000/0000", wbus, rbus); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_done_busy: got %b want 0", busy); end
        tick;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_back_to_back;
        int rs [6];
        int rd [6];
        int ti;
        int di;
        int last_c;
        rs = '{0, 1, 2, 3, 0, 2};
        rd = '{1, 2, 3, 0, 3, 1};
        ti = 0; di = 0; last_c = 0;
        for (int c = 0; c < 30; c++) begin
            if (c < 6) begin
                valid = 1'b1; src = 3'(rs[c]); dst = 3'(rd[c]);
                checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d: got %b want 1", c, ready); end
            end else begin
                valid = 1'b0;
            end
            tick;
            if (c == 5) begin
                checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready: got %b want 0", ready); end
            end
            if (rbus !== 4'b0000) begin
                checks++;
                if (ti >= 6) begin
                    errors++; $display("FAIL b2b_extra_xfer: got transfer %0d want at most 6", ti);
                end else if (wbus !== oh(rs[ti]) || rbus !== oh(rd[ti])) begin
                    errors++; $display("FAIL b2b_order_%0d: got %b/%b want %b/%b", ti, wbus, rbus, oh(rs[ti]), oh(rd[ti]));
                end
                ti++;
            end
            if (done === 1'b1) begin
                if (di > 0) begin
                    checks++; if (c - last_c != 3) begin errors++; $display("FAIL b2b_spacing_%0d: got %0d want 3", di, c - last_c); end
                end
                checks++;
                if (di == 5 && busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end: got %b want 0", busy); end
                else if (di < 5 && busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_mid_%0d: got %b want 1", di, busy); end
                last_c = c;
                di++;
            end
        end
        checks++; if (di != 6) begin errors++; $display("FAIL b2b_done_count: got %0d want 6", di); end
        checks++; if (ti != 6) begin errors++; $display("FAIL b2b_xfer_count: got %0d want 6", ti); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_final: got %b want 0", busy); end
    endtask

    task automatic test_reject;
        int sv [3];
        int dv [3];
        sv = '{2, 0, 7};
        dv = '{2, 5, 1};
        for (int k = 0; k < 3; k++) begin
            valid = 1'b1; src = 3'(sv[k]); dst = 3'(dv[k]);
            tick;
            valid = 1'b0;
            checks++; if (reject !== 1'b1) begin errors++; $display("FAIL reject_pulse_%0d: got %b want 1", k, reject); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reject_busy_%0d: got %b want 0", k, busy); end
            tick;
            checks++; if (reject !== 1'b0) begin errors++; $display("FAIL reject_clear_%0d: got %b want 0", k, reject); end
            checks++; if ((wbus | rbus) !== 4'b0000) begin errors++; $display("FAIL reject_enables_%0d: got %b/%b want 0000/0000", k, wbus, rbus); end
        end
    endtask

    task automatic test_reset_abort;
        int bad;
        valid = 1'b1; src = 3'd1; dst = 3'd0; tick;
        src = 3'd2; dst = 3'd1; tick;
        src = 3'd3; dst = 3'd2; tick;
        checks++; if (wbus !== 4'b0010 || rbus !== 4'b0001) begin errors++; $display("FAIL abort_in_xfer: got %b/%b want 0010/0001", wbus, rbus); end
        rst = 1'b1; src = 3'd0; dst = 3'd1;
        tick;
        rst = 1'b0; valid = 1'b0;
        checks++; if ((wbus | rbus) !== 4'b0000) begin errors++; $display("FAIL abort_enables: got %b/%b want 0000/0000", wbus, rbus); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b want 1", ready); end
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            tick;
            if (wbus !== 4'b0000 || done !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL abort_quiet: got %0d active cycles want 0", bad); end
    endtask

    task automatic test_random;
        int  exp_done;
        int  got_done;
        int  drain;
        logic accept;
        logic bad_req;
        logic exp_rej;
        exp_done = 0; got_done = 0;
        for (int c = 0; c < 10000; c++) begin
            valid = ($urandom_range(0, 3) != 0);
            src   = 3'($urandom_range(0, 4));
            dst   = 3'($urandom_range(0, 4));
            accept  = valid && ready;
            bad_req = (src == dst) || (src > 3'd3) || (dst > 3'd3);
            tick;
            if (accept && !bad_req) exp_done++;
            exp_rej = accept && bad_req;
            if (done === 1'b1) got_done++;
            checks++; if ((wbus & (wbus - 4'd1)) !== 4'b0000) begin errors++; $display("FAIL rand_wbus_onehot0: got %b at cycle %0d", wbus, c); end
            checks++; if ((rbus & (rbus - 4'd1)) !== 4'b0000) begin errors++; $display("FAIL rand_rbus_onehot0: got %b at cycle %0d", rbus, c); end
            checks++; if (rbus !== 4'b0000 && wbus === 4'b0000) begin errors++; $display("FAIL rand_read_without_write: got %b/%b at cycle %0d", wbus, rbus, c); end
            checks++; if (reject !== exp_rej) begin errors++; $display("FAIL rand_reject: got %b want %b at cycle %0d", reject, exp_rej, c); end
        end
        valid = 1'b0;
        drain = 0;
        while (busy === 1'b1 && drain < 100) begin
            tick;
            drain++;
            if (done === 1'b1) got_done++;
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rand_drain_timeout: busy got %b want 0", busy); end
        tick;
        if (done === 1'b1) got_done++;
        checks++; if (got_done != exp_done) begin errors++; $display("FAIL rand_done_count: got %0d want %0d", got_done, exp_done); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_reject;
        test_reset_abort;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
